// File: rtl/std_gate_pkg.sv
// std_gate_pkg: shared gate-block opcodes, operand container and the multi-operand reduce function
package std_gate_pkg;
   localparam int LU_OP_W   = 3;
   localparam int LU_MAX_IN = 8;
   localparam int LU_MAX_W  = 64;
   localparam logic [LU_OP_W-1:0] LU_OP_AND  = 3'd0;
   localparam logic [LU_OP_W-1:0] LU_OP_OR   = 3'd1;
   localparam logic [LU_OP_W-1:0] LU_OP_NAND = 3'd2;
   localparam logic [LU_OP_W-1:0] LU_OP_NOR  = 3'd3;
   localparam logic [LU_OP_W-1:0] LU_OP_XOR  = 3'd4;
   localparam logic [LU_OP_W-1:0] LU_OP_XNOR = 3'd5;
   localparam logic [LU_OP_W-1:0] LU_OP_NOT  = 3'd6;
   localparam logic [LU_OP_W-1:0] LU_OP_PASS = 3'd7;
   typedef logic [LU_MAX_IN-1:0][LU_MAX_W-1:0] lu_ops_t;
   // only the first n operands take part; unused slots are ignored, not padded
   function automatic logic [LU_MAX_W-1:0] lu_reduce(input logic [LU_OP_W-1:0] op, input lu_ops_t ops, input int n);
      logic [LU_MAX_W-1:0] a, o, x;
      a = ops[0];
      o = ops[0];
      x = ops[0];
      for (int i = 1; i < LU_MAX_IN; i++)
         if (i < n) begin
            a = a & ops[i];
            o = o | ops[i];
            x = x ^ ops[i];
         end
      return op == LU_OP_AND  ? a :
             op == LU_OP_OR   ? o :
             op == LU_OP_NAND ? ~a :
             op == LU_OP_NOR  ? ~o :
             op == LU_OP_XOR  ? x :
             op == LU_OP_XNOR ? ~x :
             op == LU_OP_NOT  ? ~ops[0] : ops[0];
   endfunction
endpackage

// File: rtl/logic_unit_skid.sv
// logic_unit_skid: one-result output register plus one skid entry; in_ready is a pure register
module logic_unit_skid #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         skid_valid, skid_next, acc, drain;
   logic [W-1:0] skid_data;
   assign acc   = in_valid & in_ready;
   assign drain = out_valid & out_ready;
   always_comb skid_next = skid_valid ? !drain : acc && out_valid && !drain;
   // in_ready stays low one extra cycle after the skid entry moves to the output
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else begin
         skid_valid <= skid_next;
         in_ready   <= !skid_next && !skid_valid;
         if (skid_valid) begin
            if (drain) out_data <= skid_data;
         end else if (acc && (!out_valid || drain)) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else if (acc)
            skid_data <= in_data;
         else if (drain)
            out_valid <= 1'b0;
      end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered NUM_IN-operand bitwise logic unit with valid/ready skid buffering
// LOGIC_UNIT_PARITY_EN adds OUT_PAR (even parity of OUT0) carried alongside the result
module logic_unit_pipe
   import std_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
   input  logic [LU_OP_W-1:0]      IN_OP,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic [WIDTH-1:0]        OUT0
`ifdef LOGIC_UNIT_PARITY_EN
   ,
   output logic                    OUT_PAR
`endif
);
`ifdef LOGIC_UNIT_PARITY_EN
   localparam int PW = WIDTH + 1;
`else
   localparam int PW = WIDTH;
`endif
   lu_ops_t             ops;
   logic [LU_MAX_W-1:0] full;
   logic [WIDTH-1:0]    res;
   logic [PW-1:0]       pin, pout;
   logic                unused;
   always_comb begin
      ops = '0;
      for (int k = 0; k < NUM_IN; k++)
         ops[k][WIDTH-1:0] = IN_DATA[k*WIDTH +: WIDTH];
   end
   assign full   = lu_reduce(IN_OP, ops, NUM_IN);
   assign res    = full[WIDTH-1:0];
   assign unused = ^full;
`ifdef LOGIC_UNIT_PARITY_EN
   assign pin     = {^res, res};
   assign OUT_PAR = pout[WIDTH];
`else
   assign pin = res;
`endif
   assign OUT0 = pout[WIDTH-1:0];
   logic_unit_skid #(.W(PW)) u_skid (
      .clk      (CLK),
      .rst      (RST),
      .in_valid (IN_VALID),
      .in_ready (IN_READY),
      .in_data  (pin),
      .out_valid(OUT_VALID),
      .out_ready(OUT_READY),
      .out_data (pout)
   );
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized scoreboard bench for logic_unit_pipe (NUM_IN=2 main, NUM_IN=3 side instance)
module tb_logic_unit_pipe;
`ifdef LOGIC_UNIT_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic        in_ready, out_valid, par_obs;
   logic [15:0] in_data = 0;
   logic [2:0]  in_op = 0;
   logic [7:0]  out0;
   logic        in_valid3 = 0, in_ready3, out_valid3, par3;
   logic [23:0] in_data3 = 0;
   logic [2:0]  in_op3 = 0;
   logic [7:0]  out3;
   int          checks = 0, errors = 0, acc = 0, emitted = 0;
   logic [8:0]  q[$];
   logic        hold_v = 0;
   logic [8:0]  hold;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .NUM_IN(2)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
      .IN_OP(in_op), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT0(out0)
`ifdef LOGIC_UNIT_PARITY_EN
      , .OUT_PAR(par_obs)
`endif
   );
   logic_unit_pipe #(.WIDTH(8), .NUM_IN(3)) dut3 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid3), .IN_READY(in_ready3), .IN_DATA(in_data3),
      .IN_OP(in_op3), .OUT_VALID(out_valid3), .OUT_READY(1'b1), .OUT0(out3)
`ifdef LOGIC_UNIT_PARITY_EN
      , .OUT_PAR(par3)
`endif
   );
`ifndef LOGIC_UNIT_PARITY_EN
   assign par_obs = 1'b0;
   assign par3    = 1'b0;
`endif

   // per-bit population count of the operands decides each result bit
   function automatic logic [7:0] model(input logic [2:0] op, input logic [23:0] d, input int n);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) begin
         int c = 0;
         for (int k = 0; k < n; k++) c += int'(d[k*8+j]);
         case (op)
            3'd0: r[j] = (c == n);
            3'd1: r[j] = (c > 0);
            3'd2: r[j] = (c != n);
            3'd3: r[j] = (c == 0);
            3'd4: r[j] = (c % 2 == 1);
            3'd5: r[j] = (c % 2 == 0);
            3'd6: r[j] = !d[j];
            default: r[j] = d[j];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] d);
      int t = 0;
      logic [7:0] r;
      in_valid = 1; in_op = op; in_data = d;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 0;
         return;
      end
      r = model(op, {8'h00, d}, 2);
      q.push_back({PAR & ^r, r});
      acc++;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   // monitor: pops the scoreboard on every output transfer, checks stability while stalled
   initial forever begin
      @(negedge clk);
      if (rst || !out_valid) hold_v = 0;
      else begin
         if (hold_v) chk("stall_stable", {23'd0, par_obs, out0}, {23'd0, hold});
         if (out_ready) begin
            hold_v = 0;
            if (q.size() == 0) chk("unexpected_output", {24'd0, out0}, 32'hDEAD);
            else begin
               chk("result", {23'd0, par_obs, out0}, {23'd0, q.pop_front()});
               emitted++;
            end
         end else begin
            hold_v = 1;
            hold = {par_obs, out0};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int e0;
      logic [8:0] first;
      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out0", out0, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      send(3'd2, {8'hCC, 8'hF0});
      chk("nand_valid", out_valid, 1);
      chk("nand_out0", out0, 8'h3F);
      chk("nand_par", par_obs, 0);
      send(3'd3, {8'h30, 8'h0F});
      chk("nor_out0", out0, 8'hC0);
      send(3'd6, {8'hFF, 8'h5A});
      chk("not_out0", out0, 8'hA5);
      @(posedge clk); #1;
      in_valid3 = 1; in_op3 = 3'd4; in_data3 = {8'h55, 8'h33, 8'h0F};
      @(posedge clk); #1;
      in_valid3 = 0;
      chk("xor3_valid", out_valid3, 1);
      chk("xor3_out0", out3, 8'h69);
      chk("xor3_par", par3, 0);
      chk("xor3_model", out3, model(3'd4, in_data3, 3));
      // full rate
      repeat (3) @(posedge clk); #1;
      e0 = emitted;
      for (int i = 0; i < 16; i++) begin
         send(3'($urandom_range(0, 7)), 16'($urandom));
         chk("full_rate_valid", out_valid, 1);
      end
      repeat (3) @(posedge clk); #1;
      chk("full_rate_count", emitted - e0, 16);
      // backpressure
      out_ready = 0;
      e0 = emitted;
      acc = 0;
      fork
         for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), 16'($urandom));
      join_none
      repeat (6) @(posedge clk); #1;
      first = q[0];
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_first", {23'd0, par_obs, out0}, {23'd0, first});
      out_ready = 1;
      wait fork;
      repeat (5) @(posedge clk); #1;
      chk("bp_emitted", emitted - e0, 4);
      chk("bp_queue_empty", q.size(), 0);
      // mid-stream reset
      out_ready = 0;
      send(3'd1, 16'($urandom));
      send(3'd0, 16'($urandom));
      #3 rst = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out0", out0, 0);
      chk("rst_in_ready", in_ready, 1);
      q.delete();
      @(negedge clk); rst = 0; out_ready = 1;
      e0 = emitted;
      @(posedge clk); #1;
      chk("post_rst_ready", in_ready, 1);
      send(3'd5, 16'($urandom));
      repeat (5) @(posedge clk); #1;
      chk("post_rst_emitted", emitted - e0, 1);
      chk("post_rst_queue", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
